muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative multi-cycle multiply/divide unit that owns the HI/LO register pair.
//  It consumes MULT/MULTU/DIV/DIVU requests issued by the decoder/ALU path and
//  holds the 64-bit result in HI/LO for MFHI/MFLO readout.
//  It accepts MTHI/MTLO writes and a start/busy/done handshake so the core can stall.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are each WIDTH bits; iteration count = WIDTH
// PORTS
//  clk      in   1      single clock, all state updates on rising edge
//  rst      in   1      synchronous reset, active-high
//  start    in   1      request strobe; accepted only when busy=0
//  op       in   2      00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
//  a        in   WIDTH  multiplicand / dividend (rs)
//  b        in   WIDTH  multiplier / divisor (rt)
//  hi_we    in   1      MTHI strobe
//  lo_we    in   1      MTLO strobe
//  wdata    in   WIDTH  MTHI/MTLO data
//  busy     out  1      operation in progress
//  done     out  1      one-cycle pulse: HI/LO hold the new result
//  hi       out  WIDTH  HI register (remainder / product[2W-1:W])
//  lo       out  WIDTH  LO register (quotient / product[W-1:0])
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0.
//   Reset wins over every other input, including in the middle of an operation.
//   An operation aborted by reset leaves no result.
//  FSM states: IDLE -> CALC -> FIX -> IDLE. busy=1 exactly in CALC and FIX.
//  IDLE:
//   - start=1: latch op.
//   - Latch |a| and |b| for signed ops, raw a and b for unsigned ops.
//   - Latch the result sign; counter=0; go to CALC.
//  CALC: one radix-2 step per cycle.
//   - Multiply: shift-add step.
//   - Divide: restoring shift-subtract step.
//   - Counter increments each step; after WIDTH steps go to FIX.
//  FIX (1 cycle):
//   - Signed ops apply the sign correction:
//     product negated if sign(a)!=sign(b);
//     quotient negated if signs differ;
//     remainder takes the sign of the dividend.
//   - hi/lo written at the FIX->IDLE edge; done=1 for the following cycle only.
//  Latency: start high in cycle 0.
//   - busy=1 in cycles 1..WIDTH+1.
//   - Cycle WIDTH+2 (34 for WIDTH=32): done=1, busy=0, hi/lo valid.
//  Handshake:
//   - start while busy=1 is ignored; no queuing.
//   - start in the done cycle is accepted; back-to-back operations are legal.
//  Arithmetic:
//   - Products are the full 2*WIDTH bits, no truncation.
//   - Unsigned ops treat a and b as unsigned.
//  Divide by zero (no exception): lo=all ones, hi=a. Applies to both DIV and DIVU.
//  Signed overflow: 0x80000000 / -1 gives lo=0x80000000, hi=0.
//  MTHI/MTLO:
//   - hi_we/lo_we write wdata in IDLE only; ignored while busy=1.
//   - If hi_we/lo_we coincide with an accepted start, the write lands first.
//     The operation result overwrites it later.
//  hi/lo are stable at all times except at the result edge or a write edge.
//   Intermediate iteration state never appears on hi/lo.
// TESTING
//  1 MULTU a=FFFFFFFF b=FFFFFFFF -> after 34 cycles hi=FFFFFFFE lo=00000001, done 1 cycle.
//  2 MULT a=FFFFFFFD(-3) b=00000007 -> hi=FFFFFFFF lo=FFFFFFEB (-21).
//  3 DIV a=FFFFFFF9(-7) b=00000002 -> lo=FFFFFFFD(-3) hi=FFFFFFFF(-1);
//    DIVU 100/7 -> lo=0000000E hi=00000002.
//  4 DIVU a=12345678 b=0 -> lo=FFFFFFFF hi=12345678;
//    DIV 80000000/FFFFFFFF -> lo=80000000 hi=0.
//  5 start and hi_we while busy -> ignored, result unchanged; rst asserted in
//    cycle 10 of a DIV -> next cycle busy=0 done=0 hi=lo=0, no done pulse later.
//  6 start in the done cycle -> second op accepted; its done arrives 34 cycles later;
//    MTLO 0xA5A5A5A5 in IDLE -> lo=A5A5A5A5 next cycle.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the core and the multiply/divide unit.
// The core drives the master side; the unit implements the slave side.
interface muldiv_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO pair.
// Works on operand magnitudes and applies the sign fix in a single FIX cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic               is_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     add_sum, mul_sum, shifted;
    logic               no_borrow;
    logic [WIDTH-1:0]   sub_res;
    logic [2*WIDTH-1:0] prod, prod_neg;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        is_signed = ~bus.op[0];
        a_mag     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

        // Multiply: acc_hi is the running upper half, acc_lo shifts the multiplier out
        add_sum   = {1'b0, acc_hi_q} + {1'b0, opnd_q};
        mul_sum   = acc_lo_q[0] ? add_sum : {1'b0, acc_hi_q};

        // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in
        shifted   = {acc_hi_q, acc_lo_q[WIDTH-1]};
        no_borrow = (shifted >= {1'b0, opnd_q});
        sub_res   = shifted[WIDTH-1:0] - opnd_q;

        prod      = {acc_hi_q, acc_lo_q};
        prod_neg  = -prod;
        quo       = div0_q ? '1 : (neg_res_q ? -acc_lo_q : acc_lo_q);
        rem       = neg_rem_q ? -acc_hi_q : acc_hi_q;

        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.hi_we) hi_d = bus.wdata;
                if (bus.lo_we) lo_d = bus.wdata;
                if (bus.start) begin
                    is_div_d  = bus.op[1];
                    neg_res_d = is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    neg_rem_d = is_signed & bus.a[WIDTH-1];
                    div0_d    = bus.op[1] & (bus.b == '0);
                    cnt_d     = '0;
                    acc_hi_d  = '0;
                    acc_lo_d  = bus.op[1] ? a_mag : b_mag;
                    opnd_d    = bus.op[1] ? b_mag : a_mag;
                    busy_d    = 1'b1;
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (is_div_q) begin
                    acc_hi_d = no_borrow ? sub_res : shifted[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], no_borrow};
                end else begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    {hi_d, lo_d} = neg_res_q ? prod_neg : prod;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random ops against
// a 64-bit arithmetic model, and hand sequences for handshake/reset corners.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    muldiv_unit_if #(.WIDTH(W)) bus ();
    muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] first_hi;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Result rules straight from the arithmetic definitions
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb;
        int     ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            2'b00: return 64'(sa * sb);
            2'b01: return {32'h0, a} * {32'h0, b};
            2'b10: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                return {32'(ia % ib), 32'(ia / ib)};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
    endtask

    // lat is negative if busy dropped early or was still high with done; -1 on timeout
    task automatic wait_done(input int intf, output int lat, output logic [31:0] rh,
                             output logic [31:0] rl, output int unstable);
        logic [31:0] h1, l1;
        logic ok;
        lat = -1; rh = '0; rl = '0; unstable = 0; ok = 1'b1; h1 = '0; l1 = '0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
                h1 = bus.hi; l1 = bus.lo; first_hi = bus.hi;
            end
            if (n == intf) begin
                bus.start = 1'b1; bus.op = 2'b01; bus.a = $urandom; bus.b = $urandom;
                bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hDEADBEEF;
            end else if (n == intf + 1) begin
                bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
            end
            if (bus.done) begin
                rh = bus.hi; rl = bus.lo;
                lat = (ok && !bus.busy) ? n : -n;
                break;
            end
            if (!bus.busy) ok = 1'b0;
            if (bus.hi !== h1 || bus.lo !== l1) unstable++;
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int intf, output int lat, output logic [31:0] rh,
                         output logic [31:0] rl, output int unstable);
        @(negedge clk);
        launch(op, a, b);
        wait_done(intf, lat, rh, rl, unstable);
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h latency=%0d", op, a, b, rh, rl, lat);
    endtask

    initial begin
        int lat, unstable, pulses;
        logic [31:0] rh, rl, ra, rb;
        logic [1:0] rop;
        logic [63:0] exp;

        rst = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[4]  = '{2'b11, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
        vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[8]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9]  = '{2'b01, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
        vecs[10] = '{2'b00, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
        vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
        vecs[12] = '{2'b10, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};

        repeat (3) @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_hi", 64'(bus.hi), 64'd0);
        check("reset_lo", 64'(bus.lo), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, lat, rh, rl, unstable);
            check($sformatf("vec%0d_hi", i), 64'(rh), 64'(vecs[i].hi));
            check($sformatf("vec%0d_lo", i), 64'(rl), 64'(vecs[i].lo));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd34);
            check($sformatf("vec%0d_stable", i), 64'(unstable), 64'd0);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 64'(bus.done), 64'd0);
            check($sformatf("vec%0d_hold", i), {bus.hi, bus.lo}, {vecs[i].hi, vecs[i].lo});
        end

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 9) == 0) ? 32'h80000000 : $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 31);
            exp = ref_model(rop, ra, rb);
            do_op(rop, ra, rb, 0, lat, rh, rl, unstable);
            check($sformatf("rand%0d_result", i), {rh, rl}, exp);
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'd34);
        end

        // start and MTHI/MTLO while busy must be ignored
        do_op(2'b11, 32'd100, 32'd7, 5, lat, rh, rl, unstable);
        check("busy_ignore_result", {rh, rl}, {32'h2, 32'hE});
        check("busy_ignore_latency", 64'(lat), 64'd34);
        check("busy_ignore_stable", 64'(unstable), 64'd0);
        @(negedge clk);
        check("busy_ignore_no_queue", 64'(bus.busy), 64'd0);

        // MTLO / MTHI in IDLE
        bus.lo_we = 1'b1; bus.wdata = 32'hA5A5A5A5;
        @(negedge clk);
        bus.lo_we = 1'b0;
        $display("mtlo wdata=a5a5a5a5 -> hi=%h lo=%h", bus.hi, bus.lo);
        check("mtlo", {bus.hi, bus.lo}, {32'h2, 32'hA5A5A5A5});
        bus.hi_we = 1'b1; bus.wdata = 32'h5A5A5A5A;
        @(negedge clk);
        bus.hi_we = 1'b0;
        $display("mthi wdata=5a5a5a5a -> hi=%h lo=%h", bus.hi, bus.lo);
        check("mthi", {bus.hi, bus.lo}, {32'h5A5A5A5A, 32'hA5A5A5A5});

        // MTHI coinciding with an accepted start: write first, result later
        @(negedge clk);
        launch(2'b01, 32'd3, 32'd5);
        bus.hi_we = 1'b1; bus.wdata = 32'hCAFEF00D;
        wait_done(0, lat, rh, rl, unstable);
        $display("mthi+multu 3*5 -> hi=%h lo=%h latency=%0d", rh, rl, lat);
        check("mthi_start_write_first", 64'(first_hi), 64'hCAFEF00D);
        check("mthi_start_result", {rh, rl}, {32'h0, 32'hF});
        check("mthi_start_latency", 64'(lat), 64'd34);

        // back-to-back: second start in the done cycle
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat, rh, rl, unstable);
        check("b2b_first", {rh, rl}, {32'hFFFFFFFE, 32'h00000001});
        launch(2'b11, 32'd100, 32'd7);
        wait_done(0, lat, rh, rl, unstable);
        $display("b2b divu 100/7 -> hi=%h lo=%h latency=%0d", rh, rl, lat);
        check("b2b_second_result", {rh, rl}, {32'h2, 32'hE});
        check("b2b_second_latency", 64'(lat), 64'd34);

        // reset in cycle 10 of a DIV aborts it with no result
        @(negedge clk);
        launch(2'b10, 32'hFFFFFFF9, 32'h2);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
        end
        check("abort_busy_before", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("reset mid-div -> busy=%0d done=%0d hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done || bus.busy) pulses++;
        end
        check("abort_no_late_done", 64'(pulses), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
